fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Sequences the 16-bit CPU's combinational instruction memory. Owns the program counter, drives the memory address, and registers each fetched word with its PC into a one-entry output slot under a valid/ready handshake toward decode. Handles control-flow redirects (branch/jump) with flush, and a HALT state entered on the halt opcode.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
HALT_OPCODE, 4'hF, value of instruction bits [15:12] that marks a halt instruction.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
imem_addr  output  16  word address to instruction memory; equals the internal PC register.
imem_data  input  16  instruction word returned combinationally for imem_addr.
redirect_valid  input  1  control-flow redirect request, single-cycle pulse or held.
redirect_pc  input  16  target PC for the redirect.
out_valid  output  1  output slot holds a valid instruction.
out_ready  input  1  decode accepts the slot this cycle.
out_instr  output  16  registered instruction word.
out_pc  output  16  PC from which out_instr was fetched.
halted  output  1  sequencer is in HALT state.
resume  input  1  leave HALT and continue fetching from the current PC.
fetch_count  output  16  number of instructions delivered (handshakes completed), wraps.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, out_valid=0, out_instr=16'h0000, out_pc=16'h0000, state=RUN, halted=0, fetch_count=0.
- States: RUN, HALT. halted=1 exactly when state=HALT.
- Combinational: imem_addr = pc. No other combinational path from inputs to outputs.
- accept = out_valid & out_ready. slot_free = ~out_valid | accept.
- Priority per cycle, highest first: redirect, then fetch, then hold.
- Redirect (redirect_valid=1, any state): pc<=redirect_pc; out_valid<=0 (held instruction dropped, even if out_ready=1 that cycle; it does not count as delivered); state<=RUN. The first fetch from the target occurs on the next cycle, so the redirect-to-out_valid latency is 2 cycles.
- Fetch (RUN, no redirect, slot_free): out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
- Hold (RUN, no redirect, slot not free): pc and slot unchanged. out_instr and out_pc stay stable while out_valid=1 and out_ready=0.
- Drain: in any state without a redirect, accept with no new fetch sets out_valid<=0.
- Halt detection: when a fetch captures a word with imem_data[15:12]==HALT_OPCODE, state<=HALT on the same edge. The halt instruction is still delivered normally. pc is left at the halt address +1. No fetch happens in HALT.
- Resume: in HALT with resume=1 and no redirect, state<=RUN. Fetching restarts on the next cycle from pc. resume in RUN is ignored.
- fetch_count increments by 1 on every accept not coincident with redirect, and wraps at 16'hFFFF.
- Steady state with out_ready held at 1 is one instruction per cycle, after 1 cycle of latency from reset release.
- Reset asserted mid-operation: all state returns to reset values immediately, and any in-flight slot is lost.

Test Plan:
- Reset release, memory word[i]=16'h1000+i, out_ready=1 -> out_valid rises 1 cycle after release; out_pc sequence 0,1,2,3 with out_instr 16'h1000,16'h1001,...; fetch_count=4 after 4 accepts.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 at out_pc=5 -> out_instr/out_pc are stable, imem_addr holds at 6; on release, out_pc=5 is accepted, then 6.
- Redirect to 16'h0040 while the slot holds pc=7 with out_ready=1 -> pc=7 is not counted; out_valid=0 next cycle; then out_pc=16'h0040, then 16'h0041.
- Halt: word at 16'h0003 = 16'hF000 -> instruction 3 is delivered, halted=1, imem_addr=4 and frozen, no further out_valid; pulse resume -> out_pc=4 appears 2 cycles later.
- Wrap: redirect to 16'hFFFF -> out_pc sequence 16'hFFFF then 16'h0000.
- Reset mid-stream: drop rst_n with out_valid=1, asynchronously to clk -> outputs are immediately at reset values, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the 16-bit CPU.
// Owns the program counter, addresses the combinational instruction memory and
// registers each fetched word plus its PC into a one-entry slot handed to decode
// under a valid/ready handshake. Supports redirects (which flush the slot) and a
// HALT state entered when a fetched word carries the halt opcode.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   imem_addr       word address to instruction memory (the PC register)
//   imem_data       instruction word for imem_addr (combinational memory)
//   redirect_valid  control-flow redirect request; redirect_pc is the target
//   out_valid/ready slot handshake toward decode
//   out_instr       registered instruction word
//   out_pc          PC that out_instr was fetched from
//   halted          high while in HALT
//   resume          leave HALT and continue from the current PC
//   fetch_count     number of completed handshakes (wraps)
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic        halted,
  input  logic        resume,
  output logic [15:0] fetch_count
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] opc_q, opc_d;
  logic [15:0] count_q, count_d;

  logic accept;
  logic slot_free;

  assign accept    = valid_q & out_ready;
  assign slot_free = ~valid_q | accept;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    count_d = count_q;

    if (redirect_valid) begin
      // Flush: a slot accepted in the same cycle is dropped and not counted.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = StRun;
    end else begin
      if (accept) begin
        count_d = count_q + 16'd1;
      end

      unique case (state_q)
        StRun: begin
          if (slot_free) begin
            instr_d = imem_data;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 16'd1;
            // The halt word itself is still delivered; only further fetches stop.
            if (imem_data[15:12] == HALT_OPCODE) begin
              state_d = StHalt;
            end
          end
        end
        StHalt: begin
          if (accept) begin
            valid_d = 1'b0;
          end
          if (resume) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 16'h0000;
      opc_q   <= 16'h0000;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign halted      = (state_q == StHalt);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by a
// randomized phase, all compared each cycle against a transaction-level model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
  logic        resume;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  // Memory contents: word[a] = 16'h1000 + a, optionally a halt word at halt_addr.
  logic        halt_en   = 1'b0;
  logic [15:0] halt_addr = 16'h0003;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hF000;
    return 16'h1000 + a;
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_sequencer #(
    .RESET_PC   (16'h0000),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted),
    .resume        (resume),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: next address to fetch, contents of the delivery slot, halt flag,
  // and number of delivered instructions.
  logic [15:0] m_next;
  logic        m_full;
  logic [15:0] m_instr;
  logic [15:0] m_from;
  logic        m_halt;
  logic [15:0] m_count;

  task automatic model_reset();
    m_next  = 16'h0000;
    m_full  = 1'b0;
    m_instr = 16'h0000;
    m_from  = 16'h0000;
    m_halt  = 1'b0;
    m_count = 16'h0000;
  endtask

  task automatic model_step();
    logic        delivered;
    logic        was_halted;
    logic [15:0] w;
    delivered  = m_full && out_ready;
    was_halted = m_halt;
    if (redirect_valid) begin
      m_next = redirect_pc;
      m_full = 1'b0;
      m_halt = 1'b0;
    end else begin
      if (delivered) begin
        m_count = m_count + 16'd1;
        m_full  = 1'b0;
      end
      if (!was_halted && !m_full) begin
        w       = mem_word(m_next);
        m_instr = w;
        m_from  = m_next;
        m_full  = 1'b1;
        m_next  = m_next + 16'd1;
        if (w[15:12] == 4'hF) m_halt = 1'b1;
      end
      if (was_halted && resume) m_halt = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cmp_all();
    chk("imem_addr", imem_addr, m_next);
    chk("out_valid", {15'd0, out_valid}, {15'd0, m_full});
    chk("halted", {15'd0, halted}, {15'd0, m_halt});
    chk("fetch_count", fetch_count, m_count);
    if (m_full) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_pc", out_pc, m_from);
    end
  endtask

  // Clock the DUT once, advance the model with the same inputs, then compare.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    out_ready      = 1'b0;
    resume         = 1'b0;
    model_reset();
    #2;
    cmp_all();
    chk("rst_instr", out_instr, 16'h0000);
    chk("rst_pc", out_pc, 16'h0000);

    // Reset release with ready held high: one instruction per cycle.
    #10;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("first_pc", out_pc, 16'h0000);
    chk("first_instr", out_instr, 16'h1000);
    cycles(4);
    chk("stream_count", fetch_count, 16'd4);
    chk("stream_pc", out_pc, 16'h0004);

    // Backpressure with slot holding pc=5.
    cycle();
    chk("bp_pc", out_pc, 16'h0005);
    out_ready = 1'b0;
    cycles(3);
    chk("bp_hold_pc", out_pc, 16'h0005);
    chk("bp_hold_addr", imem_addr, 16'h0006);
    out_ready = 1'b1;
    cycle();
    chk("bp_next", out_pc, 16'h0006);

    // Redirect while pc=7 is being accepted: it is dropped, not counted.
    cycle();
    chk("rd_pre", out_pc, 16'h0007);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    cycle();
    redirect_valid = 1'b0;
    chk("rd_count", fetch_count, 16'd7);
    cycle();
    chk("rd_t0", out_pc, 16'h0040);
    cycle();
    chk("rd_t1", out_pc, 16'h0041);

    // Halt word at address 3.
    halt_en        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    cycle();
    redirect_valid = 1'b0;
    cycles(4);
    chk("halt_pc", out_pc, 16'h0003);
    chk("halt_flag", {15'd0, halted}, 16'd1);
    cycles(3);
    chk("halt_addr", imem_addr, 16'h0004);
    chk("halt_drained", {15'd0, out_valid}, 16'd0);
    resume = 1'b1;
    cycle();
    resume = 1'b0;
    chk("resume_empty", {15'd0, out_valid}, 16'd0);
    cycle();
    chk("resume_pc", out_pc, 16'h0004);
    halt_en = 1'b0;

    // PC wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("wrap0", out_pc, 16'hFFFF);
    cycle();
    chk("wrap1", out_pc, 16'h0000);

    // Randomized traffic, including occasional halts.
    halt_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 7))
                                                   : 16'($urandom);
      resume         = ($urandom_range(0, 4) == 0);
      halt_addr      = 16'($urandom_range(2, 6));
      cycle();
    end
    redirect_valid = 1'b0;
    resume         = 1'b0;
    halt_en        = 1'b0;
    out_ready      = 1'b0;

    // Make sure the slot is occupied, then reset asynchronously mid-cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("pre_rst_valid", {15'd0, out_valid}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    chk("async_pc", out_pc, 16'h0000);
    chk("async_instr", out_instr, 16'h0000);
    #4;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("restart_pc", out_pc, 16'h0000);
    cycles(3);
    chk("restart_count", fetch_count, 16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
